// File: rtl/anim_frame_sched_if.sv
// Command handshake bundle for the animation frame sequencer.
interface anim_frame_sched_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, output cmd_ready);
endinterface

// File: rtl/anim_frame_sched.sv
// Frame-level play/pause/step sequencer plus registered image-ROM address generator.
// Optional macro ANIM_ONESHOT_EN adds a 'oneshot' input that freezes on the last frame instead of wrapping.
module anim_frame_sched #(
  parameter int FRAME_CNT = 8,
  parameter int IMG_W     = 80,
  parameter int IMG_H     = 60,
  parameter int SCALE_SH  = 3,
  parameter int ADDR_W    = 16,
  parameter int HOLD_W    = 8,
  localparam int IDX_W    = $clog2(FRAME_CNT)
) (
  input  logic                vga_clk,
  input  logic                rst,
  input  logic [9:0]          pix_x,
  input  logic [9:0]          pix_y,
  input  logic                vsync,
  anim_frame_sched_if.slave   cmd,
  input  logic [HOLD_W-1:0]   hold_frames,
`ifdef ANIM_ONESHOT_EN
  input  logic                oneshot,
`endif
  output logic [IDX_W-1:0]    frame_idx,
  output logic                frame_tick,
  output logic                playing,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                pix_en
);

  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(IMG_W * IMG_H);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_CNT - 1);
  localparam int                X_LIM    = IMG_W << SCALE_SH;
  localparam int                Y_LIM    = IMG_H << SCALE_SH;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_STEP} state_e;
  typedef enum logic [1:0] {OP_STOP, OP_PLAY, OP_PAUSE, OP_STEP} op_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    frame_idx_q, frame_idx_d;
  logic [ADDR_W-1:0]   frame_base_q, frame_base_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                frame_tick_q, frame_tick_d;
  logic                vsync_d_q, vsync_d_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                pix_en_q, pix_en_d;

  logic                fb;
  logic                accept;
  logic                os;
  logic                hold_last;
  logic                do_adv;
  logic [HOLD_W-1:0]   hold_eff;
  op_e                 op;

`ifdef ANIM_ONESHOT_EN
  assign os = oneshot;
`else
  assign os = 1'b0;
`endif

  assign fb            = vsync & ~vsync_d_q;
  assign cmd.cmd_ready = (state_q != S_STEP);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign op            = op_e'(cmd.cmd_op);
  assign hold_eff      = (hold_frames == '0) ? HOLD_W'(1) : hold_frames;
  assign hold_last     = (hold_cnt_q >= hold_eff - HOLD_W'(1));
  assign do_adv        = fb & (((state_q == S_PLAY) & hold_last) | (state_q == S_STEP));

  // Frame-boundary action is resolved first from the current state; an accepted
  // command then overrides the state, and STOP overrides the frame position too.
  always_comb begin
    state_d      = state_q;
    frame_idx_d  = frame_idx_q;
    frame_base_d = frame_base_q;
    hold_cnt_d   = hold_cnt_q;
    frame_tick_d = 1'b0;
    vsync_d_d    = vsync;

    if (fb && state_q == S_PLAY && !hold_last)
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);

    if (do_adv) begin
      hold_cnt_d = '0;
      if (frame_idx_q == LAST_IDX) begin
        if (os) begin
          state_d = S_PAUSE;
        end else begin
          frame_idx_d  = '0;
          frame_base_d = '0;
          frame_tick_d = 1'b1;
        end
      end else begin
        frame_idx_d  = frame_idx_q + IDX_W'(1);
        frame_base_d = frame_base_q + FRAME_SZ;
        frame_tick_d = 1'b1;
      end
    end

    if (fb && state_q == S_STEP)
      state_d = S_PAUSE;

    if (accept) begin
      unique case (op)
        OP_STOP: begin
          state_d      = S_IDLE;
          frame_idx_d  = '0;
          frame_base_d = '0;
          hold_cnt_d   = '0;
          frame_tick_d = 1'b0;
        end
        OP_PLAY: begin
          if (state_q != S_PLAY) state_d = S_PLAY;
        end
        OP_PAUSE: begin
          if (state_q == S_PLAY) state_d = S_PAUSE;
        end
        OP_STEP: begin
          state_d = S_STEP;
        end
        default: ;
      endcase
    end
  end

  // Pixel to stored-image address: downscale by SCALE_SH, row offset via constant multiply.
  always_comb begin
    logic              in_img;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    in_img = (pix_x != 10'h3ff) && (pix_y != 10'h3ff) &&
             (32'(pix_x) < 32'(X_LIM)) && (32'(pix_y) < 32'(Y_LIM));
    row    = ADDR_W'(pix_y >> SCALE_SH);
    col    = ADDR_W'(pix_x >> SCALE_SH);
    pix_en_d   = in_img;
    rom_addr_d = in_img ? (frame_base_q + row * ADDR_W'(IMG_W) + col) : '0;
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_idx_q  <= '0;
      frame_base_q <= '0;
      hold_cnt_q   <= '0;
      frame_tick_q <= 1'b0;
      vsync_d_q    <= 1'b1;
      rom_addr_q   <= '0;
      pix_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_idx_q  <= frame_idx_d;
      frame_base_q <= frame_base_d;
      hold_cnt_q   <= hold_cnt_d;
      frame_tick_q <= frame_tick_d;
      vsync_d_q    <= vsync_d_d;
      rom_addr_q   <= rom_addr_d;
      pix_en_q     <= pix_en_d;
    end
  end

  assign frame_idx  = frame_idx_q;
  assign frame_tick = frame_tick_q;
  assign playing    = (state_q == S_PLAY);
  assign rom_addr   = rom_addr_q;
  assign pix_en     = pix_en_q;

endmodule
